seq_wide_adder_ctrl: RTL and testbench



---
 rtl/seq_wide_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder_ctrl.sv
// Sequential wide adder: one CHUNK-bit slice walks a WIDTH-bit add with a registered ripple carry.
// Optional subtract mode (sub port, B inverted and carry-in flipped) enabled by `define SEQ_WIDE_ADDER_SUB_EN.
module seq_wide_adder_ctrl #(
   parameter int WIDTH = 100,
   parameter int CHUNK = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SEQ_WIDE_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int IDXW   = $clog2(NCHUNK + 1);
   // Number of real operand bits in the final chunk (1..CHUNK).
   localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [IDXW-1:0]  idx_q, idx_d;

   logic             sub_eff;
   int               base;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] chunk_mask;
   logic             last_chunk;

`ifdef SEQ_WIDE_ADDER_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   // Shifting right zero-fills, so the missing high bits of a partial last chunk read as 0.
   always_comb begin
      base       = int'(idx_q) * CHUNK;
      a_chunk    = CHUNK'(a_q >> base);
      b_chunk    = CHUNK'(b_q >> base);
      chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;
      last_chunk = (idx_q == IDXW'(NCHUNK - 1));
   end

   // NOTE: every next-state signal gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && !clear) begin
               a_d     = a;
               b_d     = sub_eff ? ~b : b;
               carry_d = cin ^ sub_eff;
               idx_d   = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (clear) begin
               state_d = S_IDLE;
            end else begin
               sum_d   = (sum_q & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
               carry_d = chunk_sum[CHUNK];
               if (last_chunk) begin
                  // Above bit WIDTH-1 both operands are 0, so the true carry lands in bit LASTW.
                  cout_d  = chunk_sum[LASTW];
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IDXW'(1);
               end
            end
         end
         S_DONE: begin
            if (clear || out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         idx_q   <= idx_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_ADD);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Bench for seq_wide_adder_ctrl: a CHUNK=10 and a CHUNK=7 instance checked against {cout,sum} = a + b + cin.
// Subtract cases are exercised when SEQ_WIDE_ADDER_SUB_EN is defined.
module tb_seq_wide_adder_ctrl;

   localparam int W = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, in_valid10, in_valid7, cin, clear, out_ready, use7;
   logic [W-1:0] a, b;
`ifdef SEQ_WIDE_ADDER_SUB_EN
   logic         sub;
`endif

   logic         in_ready10, out_valid10, cout10, busy10;
   logic         in_ready7, out_valid7, cout7, busy7;
   logic [W-1:0] sum10, sum7;

   logic         o_in_ready, o_out_valid, o_cout, o_busy;
   logic [W-1:0] o_sum;

   int checks   = 0;
   int failures = 0;

   seq_wide_adder_ctrl #(.WIDTH(W), .CHUNK(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
      .a(a), .b(b), .cin(cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
      .sub(sub),
`endif
      .clear(clear), .out_valid(out_valid10), .out_ready(out_ready),
      .sum(sum10), .cout(cout10), .busy(busy10)
   );

   seq_wide_adder_ctrl #(.WIDTH(W), .CHUNK(7)) dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
      .a(a), .b(b), .cin(cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
      .sub(sub),
`endif
      .clear(clear), .out_valid(out_valid7), .out_ready(out_ready),
      .sum(sum7), .cout(cout7), .busy(busy7)
   );

   always_comb begin
      o_in_ready  = use7 ? in_ready7  : in_ready10;
      o_out_valid = use7 ? out_valid7 : out_valid10;
      o_cout      = use7 ? cout7      : cout10;
      o_busy      = use7 ? busy7      : busy10;
      o_sum       = use7 ? sum7       : sum10;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                        input logic tc, input logic ts);
      logic [W-1:0] bb;
      bb = ts ? ~tb_v : tb_v;
      return {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, tc ^ ts};
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[W-1:0];
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One full transaction: accept, count latency, optional back-pressure, compare, handshake.
   task automatic txn(input logic sel, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic tc, input logic ts, input int nchunk, input int hold);
      logic [W:0] exp;
      int         cnt;
      use7 = sel;
      #1;
      cnt = 0;
      while (!o_in_ready && cnt < 20) begin
         step(1);
         cnt++;
      end
      check("in_ready_before_accept", {127'd0, o_in_ready}, 128'd1);
      exp = model(ta, tb_v, tc, ts);
      a   = ta;
      b   = tb_v;
      cin = tc;
`ifdef SEQ_WIDE_ADDER_SUB_EN
      sub = ts;
`endif
      if (sel) in_valid7 = 1'b1;
      else     in_valid10 = 1'b1;
      step(1);
      in_valid10 = 1'b0;
      in_valid7  = 1'b0;
      a   = rand_w();
      b   = rand_w();
      cin = ~tc;
`ifdef SEQ_WIDE_ADDER_SUB_EN
      sub = ~ts;
`endif
      check("in_ready_drop", {127'd0, o_in_ready}, 128'd0);
      check("busy_in_add", {127'd0, o_busy}, 128'd1);
      cnt = 0;
      while (!o_out_valid && cnt < 60) begin
         step(1);
         cnt++;
      end
      check("latency", 128'(cnt), 128'(nchunk));
      check("sum", 128'(o_sum), 128'(exp[W-1:0]));
      check("cout", {127'd0, o_cout}, {127'd0, exp[W]});
      for (int i = 0; i < hold; i++) begin
         step(1);
         check("hold_out_valid", {127'd0, o_out_valid}, 128'd1);
         check("hold_in_ready", {127'd0, o_in_ready}, 128'd0);
         check("hold_sum", 128'(o_sum), 128'(exp[W-1:0]));
         check("hold_cout", {127'd0, o_cout}, {127'd0, exp[W]});
      end
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      check("out_valid_after_hs", {127'd0, o_out_valid}, 128'd0);
      check("in_ready_after_hs", {127'd0, o_in_ready}, 128'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation timeout");
   end

   initial begin
      logic [W-1:0] x, held;
      logic         held_c;
      int           seen;
      rst_n = 1'b0; in_valid10 = 1'b0; in_valid7 = 1'b0; a = '0; b = '0; cin = 1'b0;
      clear = 1'b0; out_ready = 1'b0; use7 = 1'b0;
`ifdef SEQ_WIDE_ADDER_SUB_EN
      sub = 1'b0;
`endif
      #2;
      check("rst_in_ready", {127'd0, o_in_ready}, 128'd1);
      check("rst_out_valid", {127'd0, o_out_valid}, 128'd0);
      check("rst_busy", {127'd0, o_busy}, 128'd0);
      check("rst_sum", 128'(o_sum), 128'd0);
      check("rst_cout", {127'd0, o_cout}, 128'd0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // Directed cases on the CHUNK=10 instance.
      txn(1'b0, 100'd1, 100'd2, 1'b0, 1'b0, 10, 0);
      txn(1'b0, {W{1'b1}}, '0, 1'b1, 1'b0, 10, 0);
      txn(1'b0, rand_w(), rand_w(), 1'b1, 1'b0, 10, 5);
      for (int i = 0; i < 8; i++)
         txn(1'b0, rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b0, 10, int'($urandom_range(0, 2)));

      // Partial last chunk on the CHUNK=7 instance.
      x = '0;
      x[99] = 1'b1;
      txn(1'b1, x, x, 1'b0, 1'b0, 15, 0);
      txn(1'b1, {W{1'b1}}, 100'd1, 1'b0, 1'b0, 15, 0);
      for (int i = 0; i < 4; i++)
         txn(1'b1, rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'b0, 15, 1);

      // Abort with clear part-way through ADD.
      use7 = 1'b0;
      a = rand_w(); b = rand_w(); cin = 1'b0;
      in_valid10 = 1'b1;
      step(1);
      in_valid10 = 1'b0;
      step(3);
      held   = o_sum;
      held_c = o_cout;
      clear  = 1'b1;
      step(1);
      clear = 1'b0;
      check("clear_in_ready", {127'd0, o_in_ready}, 128'd1);
      check("clear_busy", {127'd0, o_busy}, 128'd0);
      check("clear_out_valid", {127'd0, o_out_valid}, 128'd0);
      check("clear_sum_held", 128'(o_sum), 128'(held));
      check("clear_cout_held", {127'd0, o_cout}, {127'd0, held_c});
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (o_out_valid) seen++;
      end
      check("no_valid_after_clear", 128'(seen), 128'd0);
      txn(1'b0, 100'd5, 100'd7, 1'b0, 1'b0, 10, 0);

      // clear beats in_valid while idle.
      a = 100'd9; b = 100'd9;
      in_valid10 = 1'b1;
      clear      = 1'b1;
      step(1);
      in_valid10 = 1'b0;
      clear      = 1'b0;
      check("idle_clear_in_ready", {127'd0, o_in_ready}, 128'd1);
      check("idle_clear_busy", {127'd0, o_busy}, 128'd0);

      // Asynchronous reset in the middle of ADD.
      a = rand_w(); b = rand_w(); cin = 1'b1;
      in_valid10 = 1'b1;
      step(1);
      in_valid10 = 1'b0;
      step(4);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", {127'd0, o_in_ready}, 128'd1);
      check("arst_out_valid", {127'd0, o_out_valid}, 128'd0);
      check("arst_busy", {127'd0, o_busy}, 128'd0);
      check("arst_sum", 128'(o_sum), 128'd0);
      check("arst_cout", {127'd0, o_cout}, 128'd0);
      step(1);
      rst_n = 1'b1;
      step(1);
      txn(1'b0, 100'd5, 100'd7, 1'b0, 1'b0, 10, 0);

`ifdef SEQ_WIDE_ADDER_SUB_EN
      txn(1'b0, 100'd10, 100'd3, 1'b0, 1'b1, 10, 0);
      txn(1'b0, 100'd3, 100'd10, 1'b0, 1'b1, 10, 0);
      txn(1'b1, rand_w(), rand_w(), 1'b0, 1'b1, 15, 0);
      txn(1'b0, rand_w(), rand_w(), 1'b1, 1'b0, 10, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
